// File: rtl/kernel_unmapper_serializer.sv
// Kernel unmapper / serializer: restores original pixel order of a
// remapped 64-pixel kernel and streams it out in valid/ready beats.
module kernel_unmapper_serializer #(
    parameter int DATA_WIDTH       = 8,
    parameter int IMAGE_KERNEL_12K = 64,
    parameter int BEAT_PIXELS      = 8
) (
    input  logic                                          i_clk,
    input  logic                                          i_aresetn,
    input  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]   i_kernel_remapped,
    input  logic                                          i_kernel_valid,
    input  logic                                          i_kernel_is_odd,
    output logic                                          o_kernel_ready,
    output logic [BEAT_PIXELS*DATA_WIDTH-1:0]             o_tdata,
    output logic                                          o_tvalid,
    output logic                                          o_tlast,
    input  logic                                          i_tready
);

    localparam int NBEATS = IMAGE_KERNEL_12K / BEAT_PIXELS;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BW     = BEAT_PIXELS * DATA_WIDTH;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                                      r_state;
    logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] r_buf;
    logic [CW-1:0]                               r_cnt;
    logic                                        r_ready;
    logic                                        r_tvalid;
    logic                                        r_tlast;
    logic [BW-1:0]                               r_tdata;

    logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] w_orig;
    logic [BW-1:0]                               w_beat0;
    logic [BW-1:0]                               w_beat_next;
    logic [CW-1:0]                               w_next_cnt;

    // Remapped position of original pixel n: {i, j, k} reversed, inverted in odd mode
    function automatic logic [5:0] remap_idx(input logic [5:0] n,
                                             input logic       odd);
        logic [5:0] m;
        m = {n[1:0], n[4:2], n[5]};
        return odd ? ~m : m;
    endfunction

    assign w_next_cnt = r_cnt + 1'b1;

    // Undo the remap permutation on the presented kernel
    always_comb begin
        w_orig = '0;
        for (int n = 0; n < 64; n++) begin
            w_orig[6'(n)] = i_kernel_remapped[remap_idx(6'(n), i_kernel_is_odd)];
        end
    end

    // Beat 0 from the incoming kernel and the following beat from the buffer
    always_comb begin
        w_beat0     = '0;
        w_beat_next = '0;
        for (int p = 0; p < BEAT_PIXELS; p++) begin
            w_beat0[p*DATA_WIDTH +: DATA_WIDTH] = w_orig[6'(p)];
            w_beat_next[p*DATA_WIDTH +: DATA_WIDTH] =
                r_buf[6'(int'(w_next_cnt) * BEAT_PIXELS + p)];
        end
    end

    // Accept/send state machine with registered stream outputs
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_kernel_valid && r_ready) begin
                        r_buf    <= w_orig;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_beat0;
                        r_tlast  <= (NBEATS == 1);
                        r_state  <= S_SEND;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (r_tvalid && i_tready) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_ready  <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_cnt    <= w_next_cnt;
                            r_tdata  <= w_beat_next;
                            r_tlast  <= (w_next_cnt == LAST_BEAT);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_kernel_ready = r_ready;
    assign o_tvalid       = r_tvalid;
    assign o_tlast        = r_tlast;
    assign o_tdata        = r_tdata;

endmodule

// File: tb/tb_kernel_unmapper_serializer.sv
// Testbench for kernel_unmapper_serializer: forward-remap model feeds the
// DUT, a beat scoreboard checks the restored pixel stream.
module tb_kernel_unmapper_serializer;

    localparam int DW = 8;
    localparam int NP = 64;
    localparam int BP = 8;
    localparam int NB = NP / BP;
    localparam int BW = BP * DW;

    typedef struct packed {
        logic [BW-1:0] d;
        logic          l;
    } beat_t;

    logic                   clk  = 1'b0;
    logic                   rstn = 1'b0;
    logic [0:NP-1][DW-1:0]  kin  = '0;
    logic                   kvalid = 1'b0;
    logic                   kodd   = 1'b0;
    logic                   kready;
    logic [BW-1:0]          tdata;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready = 1'b0;

    int    passed = 0;
    int    total  = 0;
    beat_t sbq[$];

    always #5 clk = ~clk;

    kernel_unmapper_serializer #(
        .DATA_WIDTH       (DW),
        .IMAGE_KERNEL_12K (NP),
        .BEAT_PIXELS      (BP)
    ) dut (
        .i_clk             (clk),
        .i_aresetn         (rstn),
        .i_kernel_remapped (kin),
        .i_kernel_valid    (kvalid),
        .i_kernel_is_odd   (kodd),
        .o_kernel_ready    (kready),
        .o_tdata           (tdata),
        .o_tvalid          (tvalid),
        .o_tlast           (tlast),
        .i_tready          (tready)
    );

    // forward remapper: original index n -> remapped position
    function automatic logic [5:0] fwd_idx(input int n, input bit odd);
        logic [5:0] nn;
        logic [5:0] m;
        nn = 6'(n);
        m  = {nn[1:0], nn[4:2], nn[5]};
        return odd ? ~m : m;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [0:NP-1][DW-1:0] orig, input bit odd);
        beat_t e;
        for (int n = 0; n < NP; n++) kin[fwd_idx(n, odd)] = orig[n];
        kodd = odd;
        for (int b = 0; b < NB; b++) begin
            e.d = '0;
            for (int p = 0; p < BP; p++) e.d[p*DW +: DW] = orig[b*BP+p];
            e.l = (b == NB - 1);
            sbq.push_back(e);
        end
    endtask

    function automatic logic [0:NP-1][DW-1:0] rand_kernel();
        logic [0:NP-1][DW-1:0] k;
        for (int n = 0; n < NP; n++) k[n] = DW'($urandom);
        return k;
    endfunction

    task automatic test_reset;
        rstn = 1'b0;
        #12;
        total++;
        if ({kready, tvalid, tlast} !== 3'b000 || tdata !== '0)
            $display("FAIL reset_state got rdy=%b v=%b l=%b d=%h want 0",
                     kready, tvalid, tlast, tdata);
        else passed++;
        @(negedge clk);
        rstn = 1'b1;
        total++;
        if (kready !== 1'b0)
            $display("FAIL ready_before_clk got %b want 0", kready);
        else passed++;
        tick;
        total++;
        if (kready !== 1'b1)
            $display("FAIL ready_after_release got %b want 1", kready);
        else passed++;
    endtask

    task automatic test_identity(input bit odd);
        int            ev[8] = '{0, 16, 32, 48, 2, 18, 34, 50};
        int            od[8] = '{63, 47, 31, 15, 61, 45, 29, 13};
        logic [BW-1:0] e0;
        logic [DW-1:0] lastpix;
        tick;
        for (int p = 0; p < BP; p++) e0[p*DW +: DW] = DW'(odd ? od[p] : ev[p]);
        lastpix = odd ? 8'd0 : 8'd63;
        for (int m = 0; m < NP; m++) kin[m] = DW'(m);
        kodd   = odd;
        tready = 1'b1;
        kvalid = 1'b1;
        tick;
        kvalid = 1'b0;
        for (int b = 0; b < NB; b++) begin
            total++;
            if (tvalid !== 1'b1 || tlast !== (b == NB - 1) || kready !== 1'b0)
                $display("FAIL ident%0d beat%0d flags v=%b l=%b rdy=%b", odd, b,
                         tvalid, tlast, kready);
            else passed++;
            if (b == 0) begin
                total++;
                if (tdata !== e0)
                    $display("FAIL ident%0d beat0 got %h want %h", odd, tdata, e0);
                else passed++;
            end
            if (b == NB - 1) begin
                total++;
                if (tdata[BW-1 -: DW] !== lastpix)
                    $display("FAIL ident%0d lastpix got %0d want %0d", odd,
                             tdata[BW-1 -: DW], lastpix);
                else passed++;
            end
            tick;
        end
        total++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || kready !== 1'b1)
            $display("FAIL ident%0d done v=%b l=%b rdy=%b want 0 0 1", odd,
                     tvalid, tlast, kready);
        else passed++;
    endtask

    task automatic test_round_trip;
        int    sent = 0;
        int    cyc  = 0;
        beat_t e;
        tick;
        sbq.delete();
        tready = 1'b1;
        while ((sent < 100 || sbq.size() != 0) && cyc < 2000) begin
            if (tvalid && tready) begin
                total++;
                if (sbq.size() == 0)
                    $display("FAIL round_trip extra beat got %h", tdata);
                else begin
                    e = sbq.pop_front();
                    if ({tdata, tlast} !== {e.d, e.l})
                        $display("FAIL round_trip got %h/%b want %h/%b",
                                 tdata, tlast, e.d, e.l);
                    else passed++;
                end
            end
            if (kready && sent < 100) begin
                load(rand_kernel(), 1'($urandom));
                kvalid = 1'b1;
                sent++;
            end else kvalid = 1'b0;
            tick;
            cyc++;
        end
        kvalid = 1'b0;
        total++;
        if (sbq.size() != 0 || sent != 100)
            $display("FAIL round_trip timeout sent=%0d left=%0d want 100/0",
                     sent, sbq.size());
        else passed++;
    endtask

    task automatic test_backpressure;
        int            sent = 0;
        int            cyc  = 0;
        int            xfers = 0;
        int            lasts = 0;
        bit            stalled = 0;
        logic [BW-1:0] pd = '0;
        logic          pl = 1'b0;
        beat_t         e;
        tick;
        sbq.delete();
        while ((sent < 20 || sbq.size() != 0) && cyc < 6000) begin
            if (stalled) begin
                total++;
                if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl)
                    $display("FAIL stall_hold got v=%b %h/%b want 1 %h/%b",
                             tvalid, tdata, tlast, pd, pl);
                else passed++;
            end
            if (tvalid) begin
                total++;
                if (kready !== 1'b0)
                    $display("FAIL ready_while_send got %b want 0", kready);
                else passed++;
            end
            tready = ($urandom_range(0, 99) < 30);
            if (tvalid && tready) begin
                xfers++;
                if (tlast) lasts++;
                total++;
                if (sbq.size() == 0)
                    $display("FAIL bp extra beat got %h", tdata);
                else begin
                    e = sbq.pop_front();
                    if ({tdata, tlast} !== {e.d, e.l})
                        $display("FAIL bp_beat got %h/%b want %h/%b",
                                 tdata, tlast, e.d, e.l);
                    else passed++;
                end
            end
            stalled = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            if (kready && sent < 20) begin
                load(rand_kernel(), 1'($urandom));
                kvalid = 1'b1;
                sent++;
            end else if (!kready) begin
                kin    = rand_kernel();
                kodd   = 1'($urandom);
                kvalid = 1'b1;
            end else kvalid = 1'b0;
            tick;
            cyc++;
        end
        kvalid = 1'b0;
        tready = 1'b1;
        total++;
        if (xfers != 20 * NB || lasts != 20 || sbq.size() != 0)
            $display("FAIL bp_counts got xfers=%0d lasts=%0d want %0d/20",
                     xfers, lasts, 20 * NB);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int    sent = 0;
        int    cyc  = 0;
        int    beats = 0;
        int    last_cyc = -10;
        beat_t e;
        tick;
        sbq.delete();
        tready = 1'b1;
        while ((sent < 5 || sbq.size() != 0) && cyc < 500) begin
            if (tvalid) begin
                if (beats % NB == 0 && beats > 0) begin
                    total++;
                    if (cyc - last_cyc != 2)
                        $display("FAIL b2b_gap got %0d want 2", cyc - last_cyc);
                    else passed++;
                end
                total++;
                if (sbq.size() == 0)
                    $display("FAIL b2b extra beat got %h", tdata);
                else begin
                    e = sbq.pop_front();
                    if ({tdata, tlast} !== {e.d, e.l})
                        $display("FAIL b2b_beat got %h/%b want %h/%b",
                                 tdata, tlast, e.d, e.l);
                    else passed++;
                end
                if (tlast) last_cyc = cyc;
                beats++;
            end
            kvalid = (sent < 5);
            if (kready && sent < 5) begin
                load(rand_kernel(), 1'($urandom));
                sent++;
            end
            tick;
            cyc++;
        end
        kvalid = 1'b0;
        total++;
        if (beats != 5 * NB)
            $display("FAIL b2b_beats got %0d want %0d", beats, 5 * NB);
        else passed++;
    endtask

    task automatic test_reset_mid;
        beat_t e;
        tick;
        sbq.delete();
        tready = 1'b1;
        load(rand_kernel(), 1'b0);
        kvalid = 1'b1;
        tick;
        kvalid = 1'b0;
        tick;
        tick;
        tick;
        total++;
        if (tvalid !== 1'b1 || tdata !== sbq[3].d)
            $display("FAIL rst_mid beat3 got v=%b %h want 1 %h",
                     tvalid, tdata, sbq[3].d);
        else passed++;
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({kready, tvalid, tlast} !== 3'b000 || tdata !== '0)
            $display("FAIL rst_mid_async got rdy=%b v=%b l=%b d=%h want 0",
                     kready, tvalid, tlast, tdata);
        else passed++;
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick;
        total++;
        if (kready !== 1'b1 || tvalid !== 1'b0)
            $display("FAIL rst_mid_ready got rdy=%b v=%b want 1 0", kready, tvalid);
        else passed++;
        load(rand_kernel(), 1'b1);
        kvalid = 1'b1;
        tick;
        kvalid = 1'b0;
        for (int b = 0; b < NB; b++) begin
            e = sbq.pop_front();
            total++;
            if (tvalid !== 1'b1 || {tdata, tlast} !== {e.d, e.l})
                $display("FAIL rst_mid_next beat%0d got v=%b %h/%b want %h/%b",
                         b, tvalid, tdata, tlast, e.d, e.l);
            else passed++;
            tick;
        end
    endtask

    initial begin
        test_reset();
        test_identity(1'b0);
        test_identity(1'b1);
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/kernel_unmapper_serializer.md
Name: kernel_unmapper_serializer

Overview:
Inverse of the kernel remapping stage. Accepts one remapped 64-pixel kernel in parallel, restores the original pixel order (even or odd mode), and streams the kernel out in fixed-width beats over a valid/ready stream with last-beat marking. Sits after the remapped-kernel path and feeds downstream serial consumers (DMA/stream sinks).

Parameters:
DATA_WIDTH, 8, bits per pixel
IMAGE_KERNEL_12K, 64, pixels per kernel; fixed at 64 because the index permutation is hard-wired
BEAT_PIXELS, 8, pixels per output beat; power of 2, divides 64; NBEATS = 64/BEAT_PIXELS

Ports:
i_clk  in  1  clock, all logic on rising edge
i_aresetn  in  1  asynchronous active-low reset
i_kernel_remapped  in  [0:63][DATA_WIDTH-1:0]  remapped kernel, element 0 first
i_kernel_valid  in  1  kernel input valid
i_kernel_is_odd  in  1  remap mode of the presented kernel, sampled with the kernel
o_kernel_ready  out  1  block can accept a kernel
o_tdata  out  BEAT_PIXELS*DATA_WIDTH  output beat; pixel p of beat at bits [p*DATA_WIDTH +: DATA_WIDTH]
o_tvalid  out  1  beat valid
o_tlast  out  1  last beat of kernel
i_tready  in  1  downstream ready

Behaviour:
- Clock i_clk; reset i_aresetn, asynchronous, active-low. All outputs registered.
- Reset values: o_kernel_ready=0, o_tvalid=0, o_tlast=0, o_tdata=0, beat counter=0, state=IDLE, buffer=0.
- Index rule: original index n (6 bits) = {k=n[5], j=n[4:2], i=n[1:0]}; remapped index m = {n[1:0], n[4:2], n[5]} (= i*16+j*2+k). Even: orig[n] = remapped[m]. Odd: orig[n] = remapped[63-m] (bitwise ~m).
- FSM states: IDLE, SEND.
- IDLE: o_kernel_ready=1 (rises on first clock after reset release). On i_kernel_valid && o_kernel_ready: unmap combinationally per i_kernel_is_odd, store 64 pixels in buffer, clear counter, drop o_kernel_ready, go to SEND; o_tvalid=1 with beat 0 on the next cycle.
- SEND: o_tdata = buffer pixels [beat*BEAT_PIXELS .. beat*BEAT_PIXELS+BEAT_PIXELS-1], lowest index in LSBs. o_tlast=1 only when beat==NBEATS-1.
- Transfer occurs on o_tvalid && i_tready. Non-last transfer: counter+1, next beat presented the following cycle (no bubble between beats). Last transfer: o_tvalid/o_tlast drop next cycle, state IDLE, o_kernel_ready=1 the same next cycle.
- Backpressure: while o_tvalid && !i_tready, o_tdata, o_tlast, counter hold stable; no limit on stall length.
- i_kernel_valid in SEND is ignored (ready low); input data need not be held beyond the accepting cycle.
- Throughput: NBEATS+1 cycles per kernel with i_tready tied high; latency accept->first beat valid = 1 cycle.
- o_tdata after the last beat holds the last value; only o_tvalid qualifies it.
- Reset mid-operation: immediate return to reset values; partially sent kernel discarded, no o_tlast produced.
- Counter width clog2(NBEATS), max 1 bit for NBEATS=2; no wrap beyond NBEATS-1.

Test Plan:
- Even identity: remapped[m]=m, odd=0, i_tready=1 -> beat 0 pixels 0,16,32,48,2,18,34,50; 8 beats, o_tlast only on beat 7 (last pixel 63); ready high again 9 cycles after accept.
- Odd identity: same data, odd=1 -> beat 0 pixels 63,47,31,15,61,45,29,13; beat 7 ends with pixel 0.
- Round trip: random kernels through existing forward remapper (both modes) into this block -> concatenated beats equal original forward-remapper input exactly, 100 kernels.
- Backpressure: random i_tready 30% high -> beats never change while stalled, exactly 8 transfers per kernel, o_tlast count = kernel count, no kernel accepted while sending.
- Back-to-back: i_kernel_valid held high with new kernel each accept -> one-cycle gap between o_tlast transfer and next beat 0, no data loss.
- Reset during beat 3 -> outputs zero asynchronously, o_kernel_ready 1 one cycle after release, next kernel starts at beat 0.
